// File: rtl/x64_adc_stream_serializer.sv
// x64_adc_stream_serializer: captures NCH-channel ADC frames and emits enabled channels one word per clock
module x64_adc_stream_serializer #(
    parameter int NCH = 4,
    parameter int DW  = 24,
    parameter int CW  = 4,
    parameter int DCW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NCH*DW-1:0] din,
    input  logic              dinvld,
    input  logic [NCH-1:0]    chan_en,
    input  logic              ovf_clr,
    output logic [DW-1:0]     dout,
    output logic              doutvld,
    output logic [CW-1:0]     dout_chan,
    output logic              dout_sync,
    output logic              ovf,
    output logic [DCW-1:0]    drop_cnt,
    output logic              busy
);
    logic                     acc, any, ovr;
    logic [NCH-1:0]           src, ld, p_d, p_q;
    int                       kk;
    logic [DW-1:0]            word, dout_d, dout_q;
    logic [CW-1:0]            chan_d, chan_q;
    logic                     vld_d, vld_q, sync_d, sync_q, ovf_d, ovf_q, busy_d, busy_q;
    logic [DCW-1:0]           drop_d, drop_q;
    logic [NCH-1:0][DW-1:0]   d_d;
    (* shreg_extract = "no" *) logic [NCH-1:0][DW-1:0] d_q;

    // Pick the next word: a fresh frame bypasses the data regs, otherwise drain the lowest pending channel
    always_comb begin
        acc = dinvld & en;
        src = acc ? chan_en : p_q;
        any = |src;
        kk = 0;
        for (int i = NCH - 1; i >= 0; i--) if (src[i]) kk = i;
        word = '0;
        for (int i = 0; i < NCH; i++) if (i == kk) word = acc ? din[i*DW +: DW] : d_q[i];
        ld = {NCH{acc}} & chan_en;
        for (int i = 0; i < NCH; i++) d_d[i] = ld[i] ? din[i*DW +: DW] : d_q[i];
        p_d = src & ~(NCH'(1) << kk);
        busy_d = |p_d;
        vld_d = any;
        sync_d = acc & any;
        dout_d = any ? word : dout_q;
        chan_d = any ? CW'(kk) : chan_q;
        ovr = acc & (|p_q);
        ovf_d = ovr | (ovf_q & ~ovf_clr);
        drop_d = ovf_clr ? DCW'(ovr) : drop_q + DCW'(ovr && drop_q != '1);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q    <= '0;
            p_q    <= '0;
            busy_q <= 1'b0;
            vld_q  <= 1'b0;
            sync_q <= 1'b0;
            dout_q <= '0;
            chan_q <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            d_q    <= d_d;
            p_q    <= p_d;
            busy_q <= busy_d;
            vld_q  <= vld_d;
            sync_q <= sync_d;
            dout_q <= dout_d;
            chan_q <= chan_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    assign dout      = dout_q;
    assign doutvld   = vld_q;
    assign dout_chan = chan_q;
    assign dout_sync = sync_q;
    assign ovf       = ovf_q;
    assign drop_cnt  = drop_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_x64_adc_stream_serializer.sv
// tb_x64_adc_stream_serializer: directed self-checking bench for the ADC stream serializer
module tb_x64_adc_stream_serializer;
    logic        clk = 0, rst = 1, en = 0, dinvld = 0, ovf_clr = 0;
    logic [95:0] din = '0;
    logic [3:0]  chan_en = '0;
    logic [23:0] dout;
    logic        doutvld, dout_sync, ovf, busy;
    logic [3:0]  dout_chan;
    logic [15:0] drop_cnt;
    int          pass_cnt = 0, total_cnt = 0;

    localparam logic [95:0] FA = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
    localparam logic [95:0] FB = {24'h0B0003, 24'h0B0002, 24'h0B0001, 24'h0B0000};

    x64_adc_stream_serializer #(.NCH(4), .DW(24), .CW(4), .DCW(16)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .dinvld(dinvld), .chan_en(chan_en),
        .ovf_clr(ovf_clr), .dout(dout), .doutvld(doutvld), .dout_chan(dout_chan),
        .dout_sync(dout_sync), .ovf(ovf), .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        total_cnt++;
        if ({dout, doutvld, dout_chan, dout_sync, ovf, drop_cnt, busy} !== '0)
            $display("FAIL reset: got dout=%h vld=%b chan=%0d sync=%b ovf=%b drop=%0d busy=%b, want all 0",
                     dout, doutvld, dout_chan, dout_sync, ovf, drop_cnt, busy);
        else pass_cnt++;
        rst = 0;
        tick();
    endtask

    task automatic test_full_frame();
        logic [23:0] exp_w [4] = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
        en = 1; chan_en = 4'hF; din = FA; dinvld = 1;
        tick();
        dinvld = 0;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if ({doutvld, dout, dout_chan, dout_sync, busy} !== {1'b1, exp_w[i], 4'(i), i == 0, i != 3})
                $display("FAIL full_frame word %0d: got vld=%b dout=%h chan=%0d sync=%b busy=%b, want vld=1 dout=%h chan=%0d sync=%b busy=%b",
                         i, doutvld, dout, dout_chan, dout_sync, busy, exp_w[i], i, i == 0, i != 3);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if ({doutvld, dout_sync, ovf, dout, dout_chan} !== {3'b000, 24'h444444, 4'd3})
            $display("FAIL full_frame idle: got vld=%b sync=%b ovf=%b dout=%h chan=%0d, want 0 0 0 444444 3",
                     doutvld, dout_sync, ovf, dout, dout_chan);
        else pass_cnt++;
    endtask

    task automatic test_masked();
        chan_en = 4'b1010; din = FA; dinvld = 1;
        tick();
        dinvld = 0; chan_en = 4'hF;
        total_cnt++;
        if ({doutvld, dout, dout_chan, dout_sync} !== {1'b1, 24'h222222, 4'd1, 1'b1})
            $display("FAIL masked word0: got vld=%b dout=%h chan=%0d sync=%b, want 1 222222 1 1", doutvld, dout, dout_chan, dout_sync);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({doutvld, dout, dout_chan, dout_sync} !== {1'b1, 24'h444444, 4'd3, 1'b0})
            $display("FAIL masked word1: got vld=%b dout=%h chan=%0d sync=%b, want 1 444444 3 0", doutvld, dout, dout_chan, dout_sync);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({doutvld, busy} !== 2'b00)
            $display("FAIL masked end: got vld=%b busy=%b, want 0 0", doutvld, busy);
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        logic [23:0] exp_w [6] = '{24'h111111, 24'h222222, 24'h0B0000, 24'h0B0001, 24'h0B0002, 24'h0B0003};
        logic [3:0]  exp_c [6] = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd2, 4'd3};
        logic        exp_s [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        chan_en = 4'hF;
        for (int i = 0; i < 6; i++) begin
            dinvld = (i == 0 || i == 2);
            din = (i < 2) ? FA : FB;
            tick();
            total_cnt++;
            if ({doutvld, dout, dout_chan, dout_sync} !== {1'b1, exp_w[i], exp_c[i], exp_s[i]})
                $display("FAIL overrun word %0d: got vld=%b dout=%h chan=%0d sync=%b, want 1 %h %0d %b",
                         i, doutvld, dout, dout_chan, dout_sync, exp_w[i], exp_c[i], exp_s[i]);
            else pass_cnt++;
        end
        dinvld = 0;
        total_cnt++;
        if ({ovf, drop_cnt} !== {1'b1, 16'd1})
            $display("FAIL overrun flag: got ovf=%b drop=%0d, want 1 1", ovf, drop_cnt);
        else pass_cnt++;
        ovf_clr = 1;
        tick();
        ovf_clr = 0;
        total_cnt++;
        if ({ovf, drop_cnt, doutvld} !== {1'b0, 16'd0, 1'b0})
            $display("FAIL overrun clear: got ovf=%b drop=%0d vld=%b, want 0 0 0", ovf, drop_cnt, doutvld);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        din = FA; chan_en = 4'hF;
        for (int t = 0; t < 12; t++) begin
            dinvld = (t % 4 == 0);
            tick();
            total_cnt++;
            if ({doutvld, dout_chan, dout_sync} !== {1'b1, 4'(t % 4), t % 4 == 0})
                $display("FAIL back_to_back cycle %0d: got vld=%b chan=%0d sync=%b, want 1 %0d %b",
                         t, doutvld, dout_chan, dout_sync, t % 4, t % 4 == 0);
            else pass_cnt++;
        end
        dinvld = 0;
        tick();
        total_cnt++;
        if ({ovf, drop_cnt, doutvld} !== {1'b0, 16'd0, 1'b0})
            $display("FAIL back_to_back end: got ovf=%b drop=%0d vld=%b, want 0 0 0", ovf, drop_cnt, doutvld);
        else pass_cnt++;
    endtask

    task automatic test_gating();
        chan_en = 4'h0; dinvld = 1;
        tick();
        dinvld = 0; chan_en = 4'hF;
        total_cnt++;
        if ({doutvld, dout_sync, busy} !== 3'b000)
            $display("FAIL zero_mask: got vld=%b sync=%b busy=%b, want 0 0 0", doutvld, dout_sync, busy);
        else pass_cnt++;
        en = 0; dinvld = 1;
        tick();
        dinvld = 0;
        total_cnt++;
        if ({doutvld, busy, ovf} !== 3'b000)
            $display("FAIL en_low: got vld=%b busy=%b ovf=%b, want 0 0 0", doutvld, busy, ovf);
        else pass_cnt++;
        en = 1; din = FB; dinvld = 1;
        tick();
        en = 0; din = FA;
        for (int i = 1; i < 4; i++) begin
            tick();
            total_cnt++;
            if ({doutvld, dout, dout_chan, ovf} !== {1'b1, 24'h0B0000 + 24'(i), 4'(i), 1'b0})
                $display("FAIL en_fall word %0d: got vld=%b dout=%h chan=%0d ovf=%b, want 1 %h %0d 0",
                         i, doutvld, dout, dout_chan, ovf, 24'h0B0000 + 24'(i), i);
            else pass_cnt++;
        end
        dinvld = 0; en = 1;
        tick();
        total_cnt++;
        if ({doutvld, ovf} !== 2'b00)
            $display("FAIL en_fall end: got vld=%b ovf=%b, want 0 0", doutvld, ovf);
        else pass_cnt++;
    endtask

    task automatic test_saturate();
        chan_en = 4'hF; din = FA; dinvld = 1;
        for (int i = 0; i < 70000; i++) tick();
        total_cnt++;
        if ({ovf, drop_cnt} !== {1'b1, 16'hFFFF})
            $display("FAIL saturate: got ovf=%b drop=%0d, want 1 65535", ovf, drop_cnt);
        else pass_cnt++;
        ovf_clr = 1;
        tick();
        ovf_clr = 0; dinvld = 0;
        total_cnt++;
        if ({ovf, drop_cnt} !== {1'b1, 16'd1})
            $display("FAIL clr_with_overrun: got ovf=%b drop=%0d, want 1 1", ovf, drop_cnt);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset_mid();
        din = FA; chan_en = 4'hF; dinvld = 1;
        tick();
        dinvld = 0;
        tick();
        #2 rst = 1;
        #1;
        total_cnt++;
        if ({dout, doutvld, dout_chan, dout_sync, ovf, drop_cnt, busy} !== '0)
            $display("FAIL reset_mid async: got dout=%h vld=%b chan=%0d sync=%b ovf=%b drop=%0d busy=%b, want all 0",
                     dout, doutvld, dout_chan, dout_sync, ovf, drop_cnt, busy);
        else pass_cnt++;
        tick();
        rst = 0;
        tick();
        total_cnt++;
        if ({doutvld, busy} !== 2'b00)
            $display("FAIL reset_mid no_more_words: got vld=%b busy=%b, want 0 0", doutvld, busy);
        else pass_cnt++;
        din = FB; dinvld = 1;
        tick();
        dinvld = 0;
        total_cnt++;
        if ({doutvld, dout, dout_chan, dout_sync} !== {1'b1, 24'h0B0000, 4'd0, 1'b1})
            $display("FAIL reset_mid restart: got vld=%b dout=%h chan=%0d sync=%b, want 1 0b0000 0 1", doutvld, dout, dout_chan, dout_sync);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({doutvld, dout, dout_chan, dout_sync} !== {1'b1, 24'h0B0001, 4'd1, 1'b0})
            $display("FAIL reset_mid restart word1: got vld=%b dout=%h chan=%0d sync=%b, want 1 0b0001 1 0", doutvld, dout, dout_chan, dout_sync);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_masked();
        test_overrun();
        test_back_to_back();
        test_gating();
        test_saturate();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
